// File: rtl/digit_serial_sub.sv
// rtl/digit_serial_sub.sv - digit-serial two's-complement subtractor D = a - b - bi behind a start/ready/done handshake
module digit_serial_sub #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B,
    output logic             V
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = $clog2(NDIG + 1);

    generate
        if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("digit_serial_sub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [KW-1:0]    k;
    logic             br;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             a_msb;
    logic             b_msb;
    logic [DIGIT:0]   dig;
    logic             last_step;

    // One DIGIT+1-bit subtraction per cycle; the top bit is the borrow into the next digit.
    assign dig = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]} - {{DIGIT{1'b0}}, br};

    // k reaches NDIG once every digit is in res_sr; that extra RUN cycle publishes the result.
    assign last_step = (k == KW'(NDIG));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> RUN on accepted start, RUN -> DONE after publish, DONE -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last_step) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ready = 1'b0;
        endcase
    end

    // Operand latch, digit shift registers, borrow chain and result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            br     <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            D      <= '0;
            B      <= 1'b0;
            V      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bi;
                        k     <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    if (!last_step) begin
                        a_sr   <= a_sr >> DIGIT;
                        b_sr   <= b_sr >> DIGIT;
                        // New digit enters at the top so digit 0 ends up at the LSB.
                        res_sr <= (res_sr >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));
                        br     <= dig[DIGIT];
                        k      <= k + KW'(1);
                    end else begin
                        D <= res_sr;
                        B <= br;
                        V <= (a_msb ^ b_msb) & (a_msb ^ res_sr[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
